// File: rtl/cam_pkg.sv
// Shared constants for the OV7670 RGB444 capture stage: frame geometry,
// pixel field layout and FSM state encoding (also used by the bench monitor).
package cam_pkg;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int AW    = 15;

    localparam int PIX_W = 12;
    localparam int R_HI  = 11;
    localparam int R_LO  = 8;
    localparam int G_HI  = 7;
    localparam int G_LO  = 4;
    localparam int B_HI  = 3;
    localparam int B_LO  = 0;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam logic [1:0] ST_WAIT_VS_HIGH = 2'd0;
    localparam logic [1:0] ST_WAIT_VS_LOW  = 2'd1;
    localparam logic [1:0] ST_CAPTURE      = 2'd2;

    // First byte carries R in its low nibble, second byte carries G then B.
    function automatic pixel_t pack_rgb444(input logic [3:0] r, input logic [7:0] gb);
        pixel_t p;
        p[R_HI:R_LO] = r;
        p[G_HI:G_LO] = gb[7:4];
        p[B_HI:B_LO] = gb[3:0];
        return p;
    endfunction

endpackage

// File: rtl/cam_capture_rgb444_if.sv
// Camera byte stream in, frame-buffer write port out, plus FSM debug state.
// DP_RAM_regW is a one-cycle write strobe with no backpressure: addr/data are
// valid only in the cycle regW is high and the buffer must accept every strobe.
interface cam_capture_rgb444_if #(parameter int AW = cam_pkg::AW);

    logic          CAM_PCLK;
    logic          CAM_HREF;
    logic          CAM_VSYNC;
    logic [7:0]    CAM_px_data;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [11:0]   DP_RAM_data_in;
    logic          DP_RAM_regW;
    logic          frame_done;
    logic          overflow;
    logic [1:0]    dbg_state;

    modport master (
        output CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data,
        input  DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow, dbg_state
    );

    modport slave (
        input  CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data,
        output DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow, dbg_state
    );

endinterface

// File: rtl/cam_sync_edge.sv
// 2-FF synchronizer followed by a registered edge detector; level_o is delayed
// one extra stage so it lines up with rise_o/fall_o.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 capture: oversamples the camera byte stream on clk, pairs bytes into
// RGB444 pixels and writes them into the frame buffer one strobe per pixel.
module cam_capture_rgb444 #(
    parameter int IMG_W = cam_pkg::IMG_W,
    parameter int IMG_H = cam_pkg::IMG_H,
    parameter int AW    = cam_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_capture_rgb444_if.slave   bus
);

    import cam_pkg::*;

    localparam logic [AW-1:0] W_L = AW'(IMG_W);
    localparam logic [AW-1:0] H_L = AW'(IMG_H);

    logic pclk_rise, pclk_level_unused, pclk_fall_unused;
    logic href_level, href_fall, href_rise_unused;
    logic vs_level, vs_rise, vs_fall;

    cam_sync_edge u_sync_pclk (
        .clk(clk), .rst(rst), .d_i(bus.CAM_PCLK),
        .level_o(pclk_level_unused), .rise_o(pclk_rise), .fall_o(pclk_fall_unused)
    );

    cam_sync_edge u_sync_href (
        .clk(clk), .rst(rst), .d_i(bus.CAM_HREF),
        .level_o(href_level), .rise_o(href_rise_unused), .fall_o(href_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk(clk), .rst(rst), .d_i(bus.CAM_VSYNC),
        .level_o(vs_level), .rise_o(vs_rise), .fall_o(vs_fall)
    );

    // Data gets the same depth as the control paths so a byte pairs with its own PCLK edge.
    logic [7:0] px_meta_q, px_sync_q, px_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            px_meta_q <= '0;
            px_sync_q <= '0;
            px_q      <= '0;
        end else begin
            px_meta_q <= bus.CAM_px_data;
            px_sync_q <= px_meta_q;
            px_q      <= px_sync_q;
        end
    end

    logic [1:0]    state_q, state_d;
    logic          phase_q, phase_d;
    logic [3:0]    r_q, r_d;
    logic [AW-1:0] col_q, col_d;
    logic [AW-1:0] line_q, line_d;
    logic [AW-1:0] base_q, base_d;
    logic          ovf_q, ovf_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    pixel_t        data_q, data_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        r_d     = r_q;
        col_d   = col_q;
        line_d  = line_q;
        base_d  = base_q;
        ovf_d   = ovf_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            ST_WAIT_VS_HIGH: begin
                if (vs_level) state_d = ST_WAIT_VS_LOW;
            end
            ST_WAIT_VS_LOW: begin
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    col_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                // VSYNC outranks an HREF fall in the same cycle: the line is not counted.
                if (vs_rise) begin
                    done_d  = 1'b1;
                    phase_d = 1'b0;
                    state_d = ST_WAIT_VS_LOW;
                end else if (href_fall) begin
                    // line saturates at IMG_H so base_q + col_q stays inside the buffer
                    if (col_q != '0 && line_q < H_L) begin
                        line_d = line_q + AW'(1);
                        base_d = base_q + W_L;
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                end else if (pclk_rise && href_level) begin
                    if (!phase_q) begin
                        r_d     = px_q[3:0];
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < W_L && line_q < H_L) begin
                            wr_d   = 1'b1;
                            addr_d = base_q + col_q;
                            data_d = pack_rgb444(r_q, px_q);
                            col_d  = col_q + AW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_WAIT_VS_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_VS_HIGH;
            phase_q <= 1'b0;
            r_q     <= '0;
            col_q   <= '0;
            line_q  <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            r_q     <= r_d;
            col_q   <= col_d;
            line_q  <= line_d;
            base_q  <= base_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.DP_RAM_regW    = wr_q;
    assign bus.DP_RAM_addr_in = addr_q;
    assign bus.DP_RAM_data_in = data_q;
    assign bus.frame_done     = done_q;
    assign bus.overflow       = ovf_q;
    assign bus.dbg_state      = state_q;

endmodule
